mat_row_loader: RTL and testbench
=================================

MAT_ROW_LOADER -- requirements
Module: mat_row_loader

Interface
REQ-001 The module SHALL have parameter WIDTH, default 128, meaning matrix dimension (rows and columns).
REQ-002 The module SHALL have parameter WIDTH_ADDR_SIZE, default $clog2(WIDTH), meaning row/column index width.
REQ-003 The module SHALL have parameter LANES, default 8, meaning 32-bit elements per input beat; WIDTH % LANES == 0 is required.
REQ-004 The module SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-005 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The module SHALL have port start  input  1  one-cycle load request; honoured only in IDLE.
REQ-007 The module SHALL have port col_mode  input  1  0 = write rows (MAT_DATA_WRITE_ROW), 1 = write columns (MAT_DATA_WRITE_COL); sampled on an accepted start.
REQ-008 The module SHALL have port clear_first  input  1  issue MAT_DATA_WRITE_ZERO before the first vector; sampled on an accepted start.
REQ-009 The module SHALL have port first_index  input  WIDTH_ADDR_SIZE  first row/column index; sampled on an accepted start.
REQ-010 The module SHALL have port num_vectors  input  WIDTH_ADDR_SIZE+1  number of vectors to load, 0..WIDTH; sampled on an accepted start.
REQ-011 The module SHALL have port in_valid  input  1  beat available.
REQ-012 The module SHALL have port in_ready  output  1  loader accepts a beat this cycle.
REQ-013 The module SHALL have port in_data  input  LANES x 32  beat payload; lane k maps to vector element beat_cnt*LANES+k.
REQ-014 The module SHALL have port write_op  output  MatDataWriteOp_t  write command to the matrix register.
REQ-015 The module SHALL have port write_param1  output  WIDTH_ADDR_SIZE  target row/column index.
REQ-016 The module SHALL have port write_param2  output  WIDTH_ADDR_SIZE  always 0.
REQ-017 The module SHALL have port data_out  output  WIDTH x 32  assembled vector for the register's data_in.
REQ-018 The module SHALL have port busy  output  1  high in every state except IDLE.
REQ-019 The module SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-020 The FSM SHALL have states IDLE, CLEAR, FILL, WRITE, DONE.
REQ-021 On start in IDLE, the FSM SHALL latch the sampled inputs and go to CLEAR if clear_first, else FILL if num_vectors>0, else DONE.
REQ-022 CLEAR SHALL last one cycle with write_op=MAT_DATA_WRITE_ZERO, then go to FILL (num_vectors>0) or DONE.
REQ-023 in_ready SHALL be high only in FILL; a beat transfers when in_valid && in_ready.
REQ-024 Each transfer SHALL write its LANES elements into the vector buffer at offset beat_cnt*LANES and increment beat_cnt.
REQ-025 The transfer of beat WIDTH/LANES-1 SHALL move the FSM to WRITE next cycle and reset beat_cnt to 0.
REQ-026 WRITE SHALL last exactly one cycle with write_op=ROW or COL per col_mode, write_param1=current index, and data_out=the full buffer.
REQ-027 After WRITE, the index SHALL increment modulo WIDTH (WIDTH-1 wraps to 0) and remaining SHALL decrement; next state is FILL if remaining>0, else DONE.
REQ-028 DONE SHALL assert done for one cycle and return to IDLE.
REQ-029 In all states other than CLEAR and WRITE, write_op SHALL be MAT_DATA_WRITE_DISABLE.
REQ-030 data_out SHALL hold the buffer contents at all times; the buffer SHALL not be cleared between vectors.
REQ-031 Minimum latency from an accepted start to the first WRITE SHALL be WIDTH/LANES+1 cycles without clear, and +1 with clear.
REQ-032 A start asserted while busy SHALL be ignored without side effects.
REQ-033 in_valid low in FILL SHALL stall without losing beat_cnt; beats outside FILL SHALL not be consumed.

Reset
REQ-034 When reset is high at posedge, the FSM SHALL enter IDLE and beat_cnt, index and remaining SHALL clear to 0.
REQ-035 After reset, write_op SHALL be DISABLE, in_ready, busy and done SHALL be 0, and the data buffer SHALL be 0.
REQ-036 Reset mid-load SHALL abort with no further write_op other than DISABLE; partial vectors are discarded.

Verification (WIDTH=8, LANES=4)
REQ-037 The bench SHALL apply start, row mode, first_index=2, num_vectors=2, with beats always valid, and check: ROW at idx 2 on cycle 3 and at idx 3 on cycle 6, done on cycle 7, data matching beat order.
REQ-038 The bench SHALL apply clear_first=1, num_vectors=0, and check: one ZERO cycle, then a done pulse, with in_ready never high.
REQ-039 The bench SHALL apply first_index=7, num_vectors=2, col_mode=1, and check: COL at 7, then COL at 0 (wrap).
REQ-040 The bench SHALL deassert in_valid for 3 cycles between beats, and check: the WRITE is delayed by 3 cycles and data is unchanged.
REQ-041 The bench SHALL assert start while busy, and check: it is ignored; then assert reset during FILL and check IDLE next cycle, all outputs at reset values, and no WRITE.

Source files
------------

// File: rtl/mat_row_loader.sv
// mat_row_loader: streams LANES-wide beats into a WIDTH-element vector buffer
// and issues one row or column write per completed vector to a matrix register.

package mat_row_loader_pkg;
  typedef enum logic [1:0] {
    MAT_DATA_WRITE_DISABLE = 2'd0,
    MAT_DATA_WRITE_ZERO    = 2'd1,
    MAT_DATA_WRITE_ROW     = 2'd2,
    MAT_DATA_WRITE_COL     = 2'd3
  } MatDataWriteOp_t;
endpackage

module mat_row_loader
  import mat_row_loader_pkg::*;
#(
  parameter int WIDTH           = 128,
  parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH),
  parameter int LANES           = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         col_mode,
  input  logic                         clear_first,
  input  logic [WIDTH_ADDR_SIZE-1:0]   first_index,
  input  logic [WIDTH_ADDR_SIZE:0]     num_vectors,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*32-1:0]          in_data,
  output MatDataWriteOp_t              write_op,
  output logic [WIDTH_ADDR_SIZE-1:0]   write_param1,
  output logic [WIDTH_ADDR_SIZE-1:0]   write_param2,
  output logic [WIDTH*32-1:0]          data_out,
  output logic                         busy,
  output logic                         done
);

  // WIDTH must be a multiple of LANES so every vector is a whole number of beats.
  localparam int BEATS  = WIDTH / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = WIDTH_ADDR_SIZE + 1;

  localparam logic [BEAT_W-1:0]          LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [WIDTH_ADDR_SIZE-1:0] LAST_IDX  = WIDTH_ADDR_SIZE'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FILL, WRITE, DONE} state_t;

  state_t                       state_reg;
  logic [BEAT_W-1:0]            beat_cnt_reg;
  logic [WIDTH_ADDR_SIZE-1:0]   index_reg;
  logic [CNT_W-1:0]             remaining_reg;
  logic                         col_mode_reg;
  MatDataWriteOp_t              write_op_reg;
  logic [WIDTH_ADDR_SIZE-1:0]   write_param1_reg;
  logic                         in_ready_reg;
  logic                         busy_reg;
  logic                         done_reg;
  logic                         beat_fire;

  // in_ready_reg is high exactly while in FILL, so this is the accepted beat.
  assign beat_fire = in_valid && in_ready_reg;

  // Control FSM: next state and every registered output are decided together,
  // so outputs always describe the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      beat_cnt_reg     <= '0;
      index_reg        <= '0;
      remaining_reg    <= '0;
      col_mode_reg     <= 1'b0;
      write_op_reg     <= MAT_DATA_WRITE_DISABLE;
      write_param1_reg <= '0;
      in_ready_reg     <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      write_op_reg <= MAT_DATA_WRITE_DISABLE;
      in_ready_reg <= 1'b0;
      done_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            col_mode_reg  <= col_mode;
            index_reg     <= first_index;
            remaining_reg <= num_vectors;
            beat_cnt_reg  <= '0;
            busy_reg      <= 1'b1;
            if (clear_first) begin
              state_reg    <= CLEAR;
              write_op_reg <= MAT_DATA_WRITE_ZERO;
            end else if (num_vectors != '0) begin
              state_reg    <= FILL;
              in_ready_reg <= 1'b1;
            end else begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (remaining_reg != '0) begin
            state_reg    <= FILL;
            in_ready_reg <= 1'b1;
          end else begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        FILL: begin
          if (beat_fire && beat_cnt_reg == LAST_BEAT) begin
            beat_cnt_reg     <= '0;
            state_reg        <= WRITE;
            write_op_reg     <= col_mode_reg ? MAT_DATA_WRITE_COL : MAT_DATA_WRITE_ROW;
            write_param1_reg <= index_reg;
          end else begin
            in_ready_reg <= 1'b1;
            if (beat_fire) begin
              beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
            end
          end
        end
        WRITE: begin
          index_reg     <= (index_reg == LAST_IDX) ? '0 : index_reg + WIDTH_ADDR_SIZE'(1);
          remaining_reg <= remaining_reg - CNT_W'(1);
          if (remaining_reg > CNT_W'(1)) begin
            state_reg    <= FILL;
            in_ready_reg <= 1'b1;
          end else begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Vector buffer: each element captures its lane when its beat is accepted;
  // contents persist across vectors and are only cleared by reset.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_elem
    logic [31:0] elem_reg;

    // Element gi belongs to beat gi/LANES, lane gi%LANES.
    always_ff @(posedge clock) begin
      if (reset) begin
        elem_reg <= '0;
      end else if (beat_fire && beat_cnt_reg == BEAT_W'(gi / LANES)) begin
        elem_reg <= in_data[(gi % LANES)*32 +: 32];
      end
    end

    assign data_out[gi*32 +: 32] = elem_reg;
  end

  assign write_op     = write_op_reg;
  assign write_param1 = write_param1_reg;
  assign write_param2 = '0;
  assign in_ready     = in_ready_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_mat_row_loader.sv
// tb_mat_row_loader: scoreboard bench for mat_row_loader (WIDTH=8, LANES=4).
// Expected writes and done pulses are queued when a load is launched and
// checked by a negedge monitor as the DUT produces them.

module tb_mat_row_loader;
  import mat_row_loader_pkg::*;

  localparam int WIDTH = 8;
  localparam int AW    = 3;
  localparam int LANES = 4;
  localparam int BEATS = WIDTH / LANES;

  typedef struct {
    MatDataWriteOp_t    op;
    logic [AW-1:0]      idx;
    logic [WIDTH*32-1:0] data;
    int                 cyc;
  } exp_t;

  typedef struct {
    bit                 v;
    logic [LANES*32-1:0] d;
  } beat_t;

  logic                 clock;
  logic                 reset;
  logic                 start;
  logic                 col_mode;
  logic                 clear_first;
  logic [AW-1:0]        first_index;
  logic [AW:0]          num_vectors;
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*32-1:0]  in_data;
  MatDataWriteOp_t      write_op;
  logic [AW-1:0]        write_param1;
  logic [AW-1:0]        write_param2;
  logic [WIDTH*32-1:0]  data_out;
  logic                 busy;
  logic                 done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  bit forbid_ready = 0;
  bit have_cur = 0;
  beat_t cur;
  exp_t  exp_q[$];
  int    exp_done_q[$];
  beat_t beat_q[$];

  mat_row_loader #(
    .WIDTH(WIDTH),
    .WIDTH_ADDR_SIZE(AW),
    .LANES(LANES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .col_mode(col_mode),
    .clear_first(clear_first),
    .first_index(first_index),
    .num_vectors(num_vectors),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .write_op(write_op),
    .write_param1(write_param1),
    .write_param2(write_param2),
    .data_out(data_out),
    .busy(busy),
    .done(done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [WIDTH*32-1:0] got,
                       input logic [WIDTH*32-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Beat source: presents queued beats; entries with v=0 are one idle cycle each.
  initial begin
    bit take;
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(negedge clock);
      take = in_valid && in_ready;
      @(posedge clock);
      #1;
      if (have_cur && (!cur.v || take)) have_cur = 0;
      if (!have_cur && beat_q.size() > 0) begin
        cur = beat_q.pop_front();
        have_cur = 1;
      end
      in_valid = have_cur && cur.v;
      in_data  = (have_cur && cur.v) ? cur.d : '0;
    end
  end

  // Monitor: every non-DISABLE write and every done pulse must match the queue head.
  always @(negedge clock) begin
    exp_t e;
    int rel;
    if (!reset) begin
      rel = cyc - start_cyc + 1;
      if (forbid_ready) check("ready_low", in_ready, 1'b0);
      if (write_op != MAT_DATA_WRITE_DISABLE) begin
        $display("write op=%0d idx=%0d cycle=%0d data=%0h", write_op, write_param1, rel, data_out);
        check("param2", write_param2, '0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", write_op, MAT_DATA_WRITE_DISABLE);
        end else begin
          e = exp_q.pop_front();
          check("op", write_op, e.op);
          check("write_cycle", rel, e.cyc);
          if (e.op != MAT_DATA_WRITE_ZERO) begin
            check("idx", write_param1, e.idx);
            check("data", data_out, e.data);
          end
        end
      end
      if (done) begin
        $display("done cycle=%0d", rel);
        if (exp_done_q.size() == 0) check("unexpected_done", done, 1'b0);
        else check("done_cycle", rel, exp_done_q.pop_front());
      end
    end
  end

  // Random vector, queued as beats; gap idle cycles are inserted before beat 1.
  task automatic push_vec(input int gap, output logic [WIDTH*32-1:0] vec);
    for (int i = 0; i < WIDTH; i++) vec[i*32 +: 32] = $urandom;
    for (int b = 0; b < BEATS; b++) begin
      if (b == 1) repeat (gap) beat_q.push_back(beat_t'{v: 1'b0, d: '0});
      beat_q.push_back(beat_t'{v: 1'b1, d: vec[b*LANES*32 +: LANES*32]});
    end
  endtask

  task automatic exp_write(input MatDataWriteOp_t op, input logic [AW-1:0] idx,
                           input logic [WIDTH*32-1:0] data, input int c);
    exp_q.push_back(exp_t'{op: op, idx: idx, data: data, cyc: c});
  endtask

  task automatic do_start(input logic cm, input logic cf, input logic [AW-1:0] fi,
                          input logic [AW:0] nv);
    col_mode = cm; clear_first = cf; first_index = fi; num_vectors = nv;
    start = 1'b1;
    tick();
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    check("idle_in_time", n < 100, 1'b1);
    check("writes_left", exp_q.size(), 0);
    check("dones_left", exp_done_q.size(), 0);
    check("beats_left", beat_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH*32-1:0] v0, v1;
    reset = 1'b1; start = 1'b0; col_mode = 1'b0; clear_first = 1'b0;
    first_index = '0; num_vectors = '0;
    repeat (3) tick();
    @(negedge clock);
    check("rst_write_op", write_op, MAT_DATA_WRITE_DISABLE);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_data", data_out, '0);
    check("rst_param2", write_param2, '0);
    tick();
    reset = 1'b0;
    tick();

    // Two rows from index 2, beats always valid.
    push_vec(0, v0);
    push_vec(0, v1);
    exp_write(MAT_DATA_WRITE_ROW, 3'd2, v0, 3);
    exp_write(MAT_DATA_WRITE_ROW, 3'd3, v1, 6);
    exp_done_q.push_back(7);
    do_start(1'b0, 1'b0, 3'd2, 4'd2);
    wait_idle();

    // Clear only: one ZERO cycle, then done, in_ready never high.
    forbid_ready = 1;
    exp_write(MAT_DATA_WRITE_ZERO, '0, '0, 1);
    exp_done_q.push_back(2);
    do_start(1'b0, 1'b1, 3'd5, 4'd0);
    wait_idle();
    forbid_ready = 0;

    // Clear then one row: first write one cycle later.
    push_vec(0, v0);
    exp_write(MAT_DATA_WRITE_ZERO, '0, '0, 1);
    exp_write(MAT_DATA_WRITE_ROW, 3'd0, v0, 4);
    exp_done_q.push_back(5);
    do_start(1'b0, 1'b1, 3'd0, 4'd1);
    wait_idle();

    // Columns wrapping from 7 to 0.
    push_vec(0, v0);
    push_vec(0, v1);
    exp_write(MAT_DATA_WRITE_COL, 3'd7, v0, 3);
    exp_write(MAT_DATA_WRITE_COL, 3'd0, v1, 6);
    exp_done_q.push_back(7);
    do_start(1'b1, 1'b0, 3'd7, 4'd2);
    wait_idle();

    // Three idle cycles between beats delay the write by three.
    push_vec(3, v0);
    exp_write(MAT_DATA_WRITE_ROW, 3'd1, v0, 6);
    exp_done_q.push_back(7);
    do_start(1'b0, 1'b0, 3'd1, 4'd1);
    wait_idle();

    // Start while busy is ignored.
    push_vec(0, v0);
    exp_write(MAT_DATA_WRITE_ROW, 3'd4, v0, 3);
    exp_done_q.push_back(4);
    do_start(1'b0, 1'b0, 3'd4, 4'd1);
    col_mode = 1'b1; clear_first = 1'b1; first_index = 3'd1; num_vectors = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();

    // Reset during FILL aborts: IDLE outputs and no write afterwards.
    push_vec(0, v0);
    do_start(1'b0, 1'b0, 3'd3, 4'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    beat_q.delete();
    have_cur = 0;
    in_valid = 1'b0;
    @(negedge clock);
    check("abort_write_op", write_op, MAT_DATA_WRITE_DISABLE);
    check("abort_in_ready", in_ready, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_data", data_out, '0);
    check("abort_param1", write_param1, '0);
    repeat (8) tick();
    check("abort_stay_idle", busy, 1'b0);
    check("abort_writes_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
